bcd_counter_n: RTL and testbench

Parametrised N-digit BCD up/down counter that feeds the multiplexed 7-segment display path. It takes single-cycle debounced pulses (count up, count down, clear, load). It adds up/down counting, parallel load, wrap/saturate mode and overflow/underflow flags. Its packed BCD output connects digit-for-digit to the display driver.

---
 rtl/bcd_pkg.sv | 24 ++
 rtl/bcd_digit.sv | 51 +++++
 rtl/bcd_counter_n.sv | 148 ++++++++++++++
 tb/tb_bcd_counter_n.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// -----------------------------------------------------------------------------
// bcd_pkg
// Shared constants and helpers for the BCD counter datapath.
//   BCD_MAX   : largest legal BCD digit (9)
//   BCD_ZERO  : smallest legal BCD digit (0)
//   bcd_clamp : saturates a raw 4-bit nibble into the legal 0..9 range
// -----------------------------------------------------------------------------
package bcd_pkg;

    localparam logic [3:0] BCD_MAX  = 4'd9;
    localparam logic [3:0] BCD_ZERO = 4'd0;

    // Nibbles 10..15 are not BCD; map them onto 9 so no illegal digit is stored.
    function automatic logic [3:0] bcd_clamp(input logic [3:0] v);
        logic [3:0] r;
        if (v > BCD_MAX) begin
            r = BCD_MAX;
        end else begin
            r = v;
        end
        return r;
    endfunction

endpackage : bcd_pkg

// File: rtl/bcd_digit.sv
// -----------------------------------------------------------------------------
// bcd_digit
// One purely combinational BCD digit stage of the ripple carry/borrow chain.
// Ports:
//   digit_i  [3:0] : current digit value (always 0..9)
//   inc_i          : counter is incrementing this cycle
//   dec_i          : counter is decrementing this cycle
//   carry_i        : carry from the less significant digit (1 for digit 0)
//   borrow_i       : borrow from the less significant digit (1 for digit 0)
//   digit_o  [3:0] : next digit value
//   carry_o        : 9 -> 0 rollover, carries into the next digit
//   borrow_o       : 0 -> 9 rollunder, borrows from the next digit
// -----------------------------------------------------------------------------
module bcd_digit
    import bcd_pkg::*;
(
    input  logic [3:0] digit_i,
    input  logic       inc_i,
    input  logic       dec_i,
    input  logic       carry_i,
    input  logic       borrow_i,
    output logic [3:0] digit_o,
    output logic       carry_o,
    output logic       borrow_o
);

    // Next digit value plus carry/borrow out for this stage.
    always_comb begin
        digit_o  = digit_i;
        carry_o  = 1'b0;
        borrow_o = 1'b0;
        if (inc_i && carry_i) begin
            if (digit_i >= BCD_MAX) begin
                digit_o = BCD_ZERO;
                carry_o = 1'b1;
            end else begin
                digit_o = digit_i + 4'd1;
            end
        end else if (dec_i && borrow_i) begin
            if (digit_i == BCD_ZERO) begin
                digit_o  = BCD_MAX;
                borrow_o = 1'b1;
            end else begin
                digit_o = digit_i - 4'd1;
            end
        end else begin
            digit_o = digit_i;
        end
    end

endmodule : bcd_digit

// File: rtl/bcd_counter_n.sv
// -----------------------------------------------------------------------------
// bcd_counter_n
// N-digit BCD up/down counter with clear, parallel load, wrap/saturate mode
// and one-cycle overflow/underflow pulses. Drives the 7-segment display path.
// Parameters:
//   DIGITS : number of BCD digits (1..8), digit 0 least significant
//   WRAP   : 1 = roll over at all-9s / zero, 0 = saturate
// Ports:
//   CLK        : system clock, rising edge
//   RST        : synchronous active-high reset
//   up, dn     : one-cycle increment / decrement requests (both = no change)
//   clear      : one-cycle synchronous clear to zero
//   load       : one-cycle parallel load strobe
//   load_value : packed BCD load data, digit k at [4k+3:4k], clamped to 9
//   count      : registered packed BCD count
//   at_max     : count is all 9s (combinational)
//   at_zero    : count is all 0s (combinational)
//   overflow   : registered pulse, up applied at all-9s
//   underflow  : registered pulse, dn applied at zero
// Priority per edge: RST > clear > load > (up xor dn).
// -----------------------------------------------------------------------------
module bcd_counter_n
    import bcd_pkg::*;
#(
    parameter int unsigned DIGITS = 4,
    parameter bit          WRAP   = 1'b1
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  up,
    input  logic                  dn,
    input  logic                  clear,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_value,
    output logic [4*DIGITS-1:0]   count,
    output logic                  at_max,
    output logic                  at_zero,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int unsigned W = 4 * DIGITS;
    localparam logic [W-1:0] ALL_NINES = {DIGITS{BCD_MAX}};
    localparam logic [W-1:0] ALL_ZERO  = {W{1'b0}};

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;
    logic         overflow_q;
    logic         overflow_d;
    logic         underflow_q;
    logic         underflow_d;

    logic [W-1:0] step_s;        // count_q after one ripple increment/decrement
    logic [W-1:0] load_clamp_s;  // load_value with every digit limited to 9
    logic         inc_s;
    logic         dec_s;
    logic         carry_top_s;
    logic         borrow_top_s;

    // Simultaneous up and dn cancel out, so only one direction is ever active.
    assign inc_s = up & ~dn;
    assign dec_s = dn & ~up;

    genvar g;
    generate
        for (g = 0; g < DIGITS; g++) begin : g_digit
            logic cin_s;
            logic bin_s;
            logic cout_s;
            logic bout_s;

            // Digit 0 always sees the request itself as its carry/borrow in.
            if (g == 0) begin : g_lsd
                assign cin_s = 1'b1;
                assign bin_s = 1'b1;
            end else begin : g_upper
                assign cin_s = g_digit[g-1].cout_s;
                assign bin_s = g_digit[g-1].bout_s;
            end

            bcd_digit u_digit (
                .digit_i  (count_q[4*g +: 4]),
                .inc_i    (inc_s),
                .dec_i    (dec_s),
                .carry_i  (cin_s),
                .borrow_i (bin_s),
                .digit_o  (step_s[4*g +: 4]),
                .carry_o  (cout_s),
                .borrow_o (bout_s)
            );

            assign load_clamp_s[4*g +: 4] = bcd_clamp(load_value[4*g +: 4]);
        end
    endgenerate

    assign carry_top_s  = g_digit[DIGITS-1].cout_s;
    assign borrow_top_s = g_digit[DIGITS-1].bout_s;

    // Priority mux for the next count and the flag pulses (RST handled in the register).
    always_comb begin
        count_d     = count_q;
        overflow_d  = 1'b0;
        underflow_d = 1'b0;
        if (clear) begin
            count_d = ALL_ZERO;
        end else if (load) begin
            count_d = load_clamp_s;
        end else if (inc_s) begin
            if (carry_top_s) begin
                overflow_d = 1'b1;
                // The ripple result is already all zeros; saturating keeps all 9s.
                count_d    = WRAP ? step_s : count_q;
            end else begin
                count_d = step_s;
            end
        end else if (dec_s) begin
            if (borrow_top_s) begin
                underflow_d = 1'b1;
                // The ripple result is already all 9s; saturating keeps zero.
                count_d     = WRAP ? step_s : count_q;
            end else begin
                count_d = step_s;
            end
        end else begin
            count_d = count_q;
        end
    end

    // Count and flag registers with synchronous reset.
    always_ff @(posedge CLK) begin
        if (RST) begin
            count_q     <= ALL_ZERO;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    assign count     = count_q;
    assign overflow  = overflow_q;
    assign underflow = underflow_q;
    assign at_max    = (count_q == ALL_NINES);
    assign at_zero   = (count_q == ALL_ZERO);

endmodule : bcd_counter_n

// File: tb/tb_bcd_counter_n.sv
// -----------------------------------------------------------------------------
// tb_bcd_counter_n
// Drives a wrapping and a saturating 4-digit counter with the same stimulus
// and compares both against an integer-arithmetic reference model.
// -----------------------------------------------------------------------------
module tb_bcd_counter_n;

    localparam int DIGITS = 4;
    localparam int MAXV   = 9999;

    logic        CLK;
    logic        RST;
    logic        up;
    logic        dn;
    logic        clear;
    logic        load;
    logic [15:0] load_value;

    logic [15:0] count_w, count_s;
    logic        at_max_w, at_max_s;
    logic        at_zero_w, at_zero_s;
    logic        ovf_w, ovf_s;
    logic        unf_w, unf_s;

    int checks;
    int failures;

    // Model state: index 0 = wrapping instance, 1 = saturating instance.
    int m_cnt [2];
    bit m_ovf [2];
    bit m_unf [2];

    bcd_counter_n #(.DIGITS(DIGITS), .WRAP(1'b1)) u_wrap (
        .CLK(CLK), .RST(RST), .up(up), .dn(dn), .clear(clear), .load(load),
        .load_value(load_value), .count(count_w), .at_max(at_max_w),
        .at_zero(at_zero_w), .overflow(ovf_w), .underflow(unf_w)
    );

    bcd_counter_n #(.DIGITS(DIGITS), .WRAP(1'b0)) u_sat (
        .CLK(CLK), .RST(RST), .up(up), .dn(dn), .clear(clear), .load(load),
        .load_value(load_value), .count(count_s), .at_max(at_max_s),
        .at_zero(at_zero_s), .overflow(ovf_s), .underflow(unf_s)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Integer 0..9999 to packed BCD.
    function automatic logic [15:0] to_bcd(input int v);
        logic [15:0] r;
        int t;
        t = v;
        r = 16'h0000;
        for (int k = 0; k < DIGITS; k++) begin
            r[4*k +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    // Packed load word to integer, each nibble limited to 9.
    function automatic int load_to_int(input logic [15:0] lv);
        int v;
        int mult;
        int d;
        v = 0;
        mult = 1;
        for (int k = 0; k < DIGITS; k++) begin
            d = int'(lv[4*k +: 4]);
            if (d > 9) d = 9;
            v = v + d * mult;
            mult = mult * 10;
        end
        return v;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_step(input bit r, input bit u, input bit d, input bit c,
                              input bit l, input logic [15:0] lv);
        for (int i = 0; i < 2; i++) begin
            m_ovf[i] = 1'b0;
            m_unf[i] = 1'b0;
            if (r || c) begin
                m_cnt[i] = 0;
            end else if (l) begin
                m_cnt[i] = load_to_int(lv);
            end else if (u && !d) begin
                if (m_cnt[i] == MAXV) begin
                    m_ovf[i] = 1'b1;
                    m_cnt[i] = (i == 0) ? 0 : MAXV;
                end else begin
                    m_cnt[i] = m_cnt[i] + 1;
                end
            end else if (d && !u) begin
                if (m_cnt[i] == 0) begin
                    m_unf[i] = 1'b1;
                    m_cnt[i] = (i == 0) ? MAXV : 0;
                end else begin
                    m_cnt[i] = m_cnt[i] - 1;
                end
            end
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".w.count"}, {16'h0, count_w},   {16'h0, to_bcd(m_cnt[0])});
        check({tag, ".w.max"},   {31'h0, at_max_w},  {31'h0, m_cnt[0] == MAXV});
        check({tag, ".w.zero"},  {31'h0, at_zero_w}, {31'h0, m_cnt[0] == 0});
        check({tag, ".w.ovf"},   {31'h0, ovf_w},     {31'h0, m_ovf[0]});
        check({tag, ".w.unf"},   {31'h0, unf_w},     {31'h0, m_unf[0]});
        check({tag, ".s.count"}, {16'h0, count_s},   {16'h0, to_bcd(m_cnt[1])});
        check({tag, ".s.max"},   {31'h0, at_max_s},  {31'h0, m_cnt[1] == MAXV});
        check({tag, ".s.zero"},  {31'h0, at_zero_s}, {31'h0, m_cnt[1] == 0});
        check({tag, ".s.ovf"},   {31'h0, ovf_s},     {31'h0, m_ovf[1]});
        check({tag, ".s.unf"},   {31'h0, unf_s},     {31'h0, m_unf[1]});
    endtask

    // Drive one cycle of requests, advance the model on the edge, check after it.
    task automatic apply(input string tag, input bit r, input bit u, input bit d,
                         input bit c, input bit l, input logic [15:0] lv);
        RST = r; up = u; dn = d; clear = c; load = l; load_value = lv;
        @(posedge CLK);
        model_step(r, u, d, c, l, lv);
        #1;
        check_all(tag);
        @(negedge CLK);
    endtask

    initial begin
        logic [15:0] rlv;
        bit ru, rd, rc, rl, rr;
        checks = 0;
        failures = 0;
        m_cnt[0] = 0; m_cnt[1] = 0;
        m_ovf[0] = 1'b0; m_ovf[1] = 1'b0;
        m_unf[0] = 1'b0; m_unf[1] = 1'b0;
        RST = 1'b1; up = 1'b0; dn = 1'b0; clear = 1'b0; load = 1'b0;
        load_value = 16'h0000;

        // Reset for two cycles, then idle.
        apply("rst0", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
        apply("rst1", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
        apply("idle", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);

        // Multi-digit carry and borrow.
        apply("ld0999", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0999);
        apply("up1000", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000);
        apply("dn0999", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000);

        // Overflow at all 9s, pulse clears next cycle; then repeated ups.
        apply("ld9999", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h9999);
        apply("ovf1",   1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000);
        apply("ovfclr", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
        apply("ld9999b", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h9999);
        apply("upx1",   1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000);
        apply("upx2",   1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000);
        apply("upx3",   1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000);

        // Underflow at zero.
        apply("clr",    1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000);
        apply("unf1",   1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000);
        apply("unfclr", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);

        // Clamped load and priority interactions.
        apply("ldF3A7", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'hF3A7);
        apply("ldup",   1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 16'h0042);
        apply("updn",   1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0000);
        apply("clrldup", 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 16'h1234);
        apply("ld9999c", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h9999);
        apply("ovf2",   1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000);
        apply("rstovf", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
        apply("ld0000", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0000);
        apply("unf2",   1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000);
        apply("clrunf", 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0000);

        // Randomised traffic, biased towards the boundaries via occasional loads.
        for (int n = 0; n < 400; n++) begin
            ru  = ($urandom_range(0, 99) < 45);
            rd  = ($urandom_range(0, 99) < 35);
            rc  = ($urandom_range(0, 99) < 3);
            rl  = ($urandom_range(0, 99) < 8);
            rr  = ($urandom_range(0, 99) < 2);
            case ($urandom_range(0, 3))
                0:       rlv = 16'h9998;
                1:       rlv = 16'h0001;
                default: rlv = 16'($urandom_range(0, 65535));
            endcase
            apply("rand", rr, ru, rd, rc, rl, rlv);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_bcd_counter_n
